// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, 8 data bits + odd parity,
// stop, device ack; owns the bus (rx_inhibit) from accept to done.
module ps2_host_tx #(
  parameter int unsigned CLKS_PER_US      = 16,
  parameter int unsigned INHIBIT_US       = 120,
  parameter int unsigned START_TIMEOUT_US = 15000,
  parameter int unsigned FRAME_TIMEOUT_US = 2000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic       rx_inhibit
);

  localparam int unsigned INHIBIT_CYC = INHIBIT_US * CLKS_PER_US;
  localparam int unsigned START_CYC   = START_TIMEOUT_US * CLKS_PER_US;
  localparam int unsigned FRAME_CYC   = FRAME_TIMEOUT_US * CLKS_PER_US;
  localparam int unsigned MAX_TO      = (START_CYC > FRAME_CYC) ? START_CYC : FRAME_CYC;
  localparam int unsigned MAX_CYC     = (MAX_TO > INHIBIT_CYC) ? MAX_TO : INHIBIT_CYC;
  localparam int unsigned CNT_W       = $clog2(MAX_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_RTS,
    S_DATA,
    S_ACK,
    S_RELEASE_WAIT
  } state_t;

  state_t           state;
  logic [1:0]       clk_sync;
  logic [1:0]       data_sync;
  logic             clk_prev;
  logic             sync_clk;
  logic             sync_data;
  logic             fall;
  logic [7:0]       shreg;
  logic             parity;
  logic [3:0]       edge_cnt;
  logic [CNT_W-1:0] cnt;
  logic             timeout;

  assign sync_clk   = clk_sync[1];
  assign sync_data  = data_sync[1];
  assign fall       = clk_prev & ~sync_clk;
  // Fires on the cycle the counter would step down to zero.
  assign timeout    = (cnt == CNT_W'(1));
  assign rx_inhibit = busy;

  // Synchronizers reset to the idle bus level so reset release never looks like an edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync  <= '1;
      data_sync <= '1;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk_in};
      data_sync <= {data_sync[0], ps2_data_in};
      clk_prev  <= sync_clk;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      shreg       <= '0;
      parity      <= 1'b0;
      edge_cnt    <= '0;
      cnt         <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (tx_start) begin
            shreg       <= tx_data;
            parity      <= ~^tx_data;
            error       <= 1'b0;
            busy        <= 1'b1;
            ps2_clk_oe  <= 1'b1;
            ps2_data_oe <= 1'b0;
            cnt         <= CNT_W'(INHIBIT_CYC - 1);
            state       <= S_INHIBIT;
          end
        end
        S_INHIBIT: begin
          if (cnt == '0) begin
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b1;
            cnt         <= CNT_W'(START_CYC);
            state       <= S_RTS;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          // RTS through RELEASE_WAIT share one timeout path.
          if (timeout) begin
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            error       <= 1'b1;
            done        <= 1'b1;
            busy        <= 1'b0;
            state       <= S_IDLE;
          end else begin
            cnt <= cnt - 1'b1;
            case (state)
              S_RTS: begin
                if (fall) begin
                  ps2_data_oe <= ~shreg[0];
                  edge_cnt    <= 4'd1;
                  cnt         <= CNT_W'(FRAME_CYC);
                  state       <= S_DATA;
                end
              end
              S_DATA: begin
                if (fall) begin
                  edge_cnt <= edge_cnt + 1'b1;
                  if (edge_cnt < 4'd8) begin
                    ps2_data_oe <= ~shreg[edge_cnt[2:0]];
                  end else if (edge_cnt == 4'd8) begin
                    ps2_data_oe <= ~parity;
                  end else begin
                    ps2_data_oe <= 1'b0;
                    state       <= S_ACK;
                  end
                end
              end
              S_ACK: begin
                if (fall) begin
                  if (sync_data) error <= 1'b1;
                  state <= S_RELEASE_WAIT;
                end
              end
              S_RELEASE_WAIT: begin
                if (sync_clk && sync_data) begin
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= S_IDLE;
                end
              end
              default: state <= S_IDLE;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

PS/2 host-to-device transmitter that sends one command byte per request. Typical commands are keyboard LED control (0xED) and reset (0xFF). It is the transmit counterpart of the PS/2 receive path in the keypad block. It runs on cpu_clk, drives the open-drain ps2_clk/ps2_data pads through low-enable outputs, and raises `rx_inhibit` while it owns the bus so the receiver ignores host-generated traffic.

## Interface
- CLKS_PER_US, 16, clk cycles per microsecond (cpu_clk = 16 MHz)
- INHIBIT_US, 120, duration the host holds ps2 clock low before request-to-send (protocol minimum 100)
- START_TIMEOUT_US, 15000, limit from clock release to the device's first falling clock edge
- FRAME_TIMEOUT_US, 2000, limit from the first falling edge to the ack edge
- clk  in  1  system clock (cpu_clk)
- reset_n  in  1  asynchronous, active-low reset
- ps2_clk_in  in  1  raw ps2 clock pad level
- ps2_data_in  in  1  raw ps2 data pad level
- ps2_clk_oe  out  1  1 = pull ps2 clock low; 0 = release
- ps2_data_oe  out  1  1 = pull ps2 data low; 0 = release
- tx_data  in  8  byte to send; sampled on an accepted tx_start
- tx_start  in  1  one-cycle request; accepted only when busy = 0
- busy  out  1  high from the accept cycle to completion
- done  out  1  one-cycle pulse at completion (success or failure)
- error  out  1  valid with done; held until the next accepted tx_start
- rx_inhibit  out  1  equals busy

## Operation
- Input conditioning: each pad passes a 2-FF synchronizer. A falling edge is sync_clk going 1→0 between consecutive cycles.
- Accept: in IDLE with tx_start = 1, latch tx_data into a shift register, set parity = ~^tx_data (odd parity), clear error, set busy.
- State INHIBIT: clk_oe = 1, data_oe = 0 for INHIBIT_US*CLKS_PER_US cycles.
- State RTS: data_oe = 1 (start bit), clk_oe = 0. Load the timeout counter with START_TIMEOUT_US*CLKS_PER_US. On the first falling edge, go to DATA and reload the counter with FRAME_TIMEOUT_US*CLKS_PER_US.
- State DATA: a 4-bit edge count n starts at 1 on the first edge. On falling edge n the host drives:
  - n = 1..8: data bit n-1, LSB first; data_oe = ~bit
  - n = 9: parity
  - n = 10: release data (stop bit = 1)
- State ACK: on falling edge 11, sample sync_data. 0 = ack OK; 1 = NACK and error = 1. Go to RELEASE_WAIT.
- State RELEASE_WAIT: wait until sync_clk = 1 and sync_data = 1 together, then pulse done, drop busy, go to IDLE. This state stays under the frame timeout.
- Timeout: when the counter reaches 0 in RTS, DATA, ACK or RELEASE_WAIT:
  - clk_oe = data_oe = 0, error = 1
  - pulse done, go to IDLE
- tx_start while busy = 1: ignored, with no side effects.
- Counter width is wide enough for 240000 (18 bits at the default parameters).

## Timing
- Reset values (asynchronous): ps2_clk_oe = 0, ps2_data_oe = 0, busy = 0, done = 0, error = 0, rx_inhibit = 0; state = IDLE. Asserting reset_n low mid-frame releases both lines immediately, without waiting for clk.
- All outputs are registered.
- busy rises the cycle after the accepted tx_start. clk_oe rises the same cycle.
- INHIBIT lasts exactly INHIBIT_US*CLKS_PER_US cycles with clk_oe = 1. data_oe rises in the cycle clk_oe falls, so there is no gap with both lines released.
- Data output updates 3 cycles after the pad falling edge (2 sync stages + 1 register). This is well inside the roughly 30 µs clock-low phase.
- done is high for exactly one cycle. busy falls in the same cycle. A new tx_start is accepted on the following cycle.
- Edges are counted only in DATA and ACK. Edges seen during INHIBIT (the host's own clock drive) are ignored.

## Test plan
- Send 0xED to a device model clocking at 12.5 kHz (1280-cycle period) that acks. Required response:
  - clk_oe high for 1920 cycles
  - bits at the device's rising edges: 0 (start), then 1,0,1,1,0,1,1,1, then parity 1, stop 1
  - done pulse with error = 0; busy high for the whole frame
- Send 0x07. Required: parity bit 0, data bits 1,1,1,0,0,0,0,0, done with error = 0.
- No device clocking. Required: done with error = 1 exactly 1920 + 240000 cycles after accept (±2); clk_oe = data_oe = 0 afterward.
- Device keeps data high at edge 11 (NACK). Required: done with error = 1 after the lines return high.
- Device stops clocking after edge 5. Required: done with error = 1 at 32000 cycles after the first edge (±2); both lines released.
- Second tx_start mid-frame: ignored, and the first frame completes unchanged. reset_n low at edge 4: oe outputs are 0 before the next clk edge and busy = 0.
